// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg: shared types and constants
// for the strobe/data input conditioning front end.
package input_conditioner_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        LO      = 2'd0,
        PEND_HI = 2'd1,
        HI      = 2'd2,
        PEND_LO = 2'd3
    } strobe_state_e;

    // Glitch event counter geometry.
    localparam int GLITCH_W = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = 8'd255;

endpackage

// File: rtl/input_conditioner_debounce.sv
// strobe_debounce: one strobe channel's debounce FSM.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   s          : synchronized strobe bit
//   level      : debounced level (registered)
//   rise, fall : one-cycle pulses on accepted edges
//   abort      : comb, pending change rejected this cycle
//   rise_nxt   : comb, rise will assert after this edge
module strobe_debounce
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s,
    output logic level,
    output logic rise,
    output logic fall,
    output logic abort,
    output logic rise_nxt
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    strobe_state_e state_q;
    strobe_state_e state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_d;
    logic          fall_nxt;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = 1'b0;
        unique case (state_q)
            LO: begin
                if (s) begin
                    state_d = PEND_HI;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_HI: begin
                if (!s) begin
                    state_d = LO;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HI;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HI: begin
                if (!s) begin
                    state_d = PEND_LO;
                    cnt_d   = CNT_ONE;
                end
            end
            PEND_LO: begin
                if (s) begin
                    state_d = HI;
                    abort   = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = LO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LO;
            end
        endcase
        // Level follows the accepted side: a pending
        // change keeps reporting the old level.
        level_d  = (state_d == HI) || (state_d == PEND_LO);
        rise_nxt = level_d & ~level;
        fall_nxt = ~level_d & level;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LO;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level   <= level_d;
            rise    <= rise_nxt;
            fall    <= fall_nxt;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronizes data/strobe pins,
// debounces strobes, captures data on accepted rises.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   data_async     : raw data pins
//   strobe_async   : raw strobe pins
//   data_in        : synchronized data
//   strobe         : debounced strobe levels
//   strobe_rise/fall : one-cycle edge pulses
//   data_captured  : data snapshot at last accepted rise
//   capture_valid  : pulse when data_captured updates
//   capture_chan   : rise vector of the last capture
//   glitch_count   : saturating rejected-change count
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DATA_W          = 4,
    parameter int STROBE_W        = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [DATA_W-1:0]   data_async,
    input  logic [STROBE_W-1:0] strobe_async,
    output logic [DATA_W-1:0]   data_in,
    output logic [STROBE_W-1:0] strobe,
    output logic [STROBE_W-1:0] strobe_rise,
    output logic [STROBE_W-1:0] strobe_fall,
    output logic [DATA_W-1:0]   data_captured,
    output logic                capture_valid,
    output logic [STROBE_W-1:0] capture_chan,
    output logic [GLITCH_W-1:0] glitch_count
);

    logic [SYNC_STAGES-1:0][DATA_W-1:0]   data_sync;
    logic [SYNC_STAGES-1:0][STROBE_W-1:0] strobe_sync;
    logic [STROBE_W-1:0]                  rise_nxt;
    logic [STROBE_W-1:0]                  abort;

    // Index 0 takes the pin; the top index is the
    // synchronized output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync   <= '0;
            strobe_sync <= '0;
        end else begin
            data_sync   <= {data_sync[SYNC_STAGES-2:0],
                            data_async};
            strobe_sync <= {strobe_sync[SYNC_STAGES-2:0],
                            strobe_async};
        end
    end

    assign data_in = data_sync[SYNC_STAGES-1];

    for (genvar g = 0; g < STROBE_W; g++) begin : g_chan
        strobe_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .s        (strobe_sync[SYNC_STAGES-1][g]),
            .level    (strobe[g]),
            .rise     (strobe_rise[g]),
            .fall     (strobe_fall[g]),
            .abort    (abort[g]),
            .rise_nxt (rise_nxt[g])
        );
    end

    // Capture on the same edge that raises strobe_rise,
    // so the snapshot is data_in from just before it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_captured <= '0;
            capture_valid <= 1'b0;
            capture_chan  <= '0;
        end else begin
            capture_valid <= |rise_nxt;
            if (|rise_nxt) begin
                data_captured <= data_in;
                capture_chan  <= rise_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            glitch_count <= '0;
        end else if (|abort && glitch_count != GLITCH_MAX) begin
            glitch_count <= glitch_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: random and directed stimulus
// checked against a run-length reference model.
module tb_input_conditioner;

    localparam int S = 2;
    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] data_async = '0;
    logic [1:0] strobe_async = '0;
    logic [3:0] data_in;
    logic [1:0] strobe;
    logic [1:0] strobe_rise;
    logic [1:0] strobe_fall;
    logic [3:0] data_captured;
    logic       capture_valid;
    logic [1:0] capture_chan;
    logic [7:0] glitch_count;

    input_conditioner #(
        .DATA_W(4),
        .STROBE_W(2),
        .SYNC_STAGES(S),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_async    (data_async),
        .strobe_async  (strobe_async),
        .data_in       (data_in),
        .strobe        (strobe),
        .strobe_rise   (strobe_rise),
        .strobe_fall   (strobe_fall),
        .data_captured (data_captured),
        .capture_valid (capture_valid),
        .capture_chan  (capture_chan),
        .glitch_count  (glitch_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: pin history queues, accepted
    // level and the length of the current run of
    // samples that disagree with it.
    logic [1:0] sq[$];
    logic [3:0] dq[$];
    logic [1:0] m_lvl;
    int         m_run[2];
    logic [1:0] m_rise;
    logic [1:0] m_fall;
    logic       m_cv;
    logic [3:0] m_cd;
    logic [1:0] m_cc;
    int         m_glitch;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sq.delete();
        dq.delete();
        for (int i = 0; i < S; i++) begin
            sq.push_back(2'b00);
            dq.push_back(4'h0);
        end
        m_lvl    = '0;
        m_run[0] = 0;
        m_run[1] = 0;
        m_rise   = '0;
        m_fall   = '0;
        m_cv     = 1'b0;
        m_cd     = '0;
        m_cc     = '0;
        m_glitch = 0;
    endtask

    task automatic model_edge(input logic [1:0] sa,
                              input logic [3:0] da);
        logic [1:0] s;
        logic [3:0] d;
        logic       ab;
        s = sq.pop_front();
        d = dq.pop_front();
        sq.push_back(sa);
        dq.push_back(da);
        m_rise = '0;
        m_fall = '0;
        ab     = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (s[c] != m_lvl[c]) begin
                m_run[c]++;
                if (m_run[c] == D + 1) begin
                    m_lvl[c] = s[c];
                    m_run[c] = 0;
                    if (s[c]) m_rise[c] = 1'b1;
                    else m_fall[c] = 1'b1;
                end
            end else begin
                if (m_run[c] != 0) ab = 1'b1;
                m_run[c] = 0;
            end
        end
        m_cv = |m_rise;
        if (m_cv) begin
            m_cd = d;
            m_cc = m_rise;
        end
        if (ab && m_glitch < 255) m_glitch++;
    endtask

    task automatic compare_all();
        chk("data_in", 32'(data_in), 32'(dq[S-1-(S-1)]));
        chk("strobe", 32'(strobe), 32'(m_lvl));
        chk("rise", 32'(strobe_rise), 32'(m_rise));
        chk("fall", 32'(strobe_fall), 32'(m_fall));
        chk("cap_valid", 32'(capture_valid), 32'(m_cv));
        chk("cap_data", 32'(data_captured), 32'(m_cd));
        chk("cap_chan", 32'(capture_chan), 32'(m_cc));
        chk("glitch", 32'(glitch_count), 32'(m_glitch));
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic step(input logic [1:0] sa,
                        input logic [3:0] da);
        strobe_async = sa;
        data_async   = da;
        @(posedge clk);
        model_edge(sa, da);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    int first;
    int cnt_a;
    int cnt_b;
    int hold[2];
    logic [1:0] rs;

    initial begin
        model_reset();
        @(negedge clk);
        // 1: pin already high through reset
        strobe_async = 2'b01;
        do_reset(3);
        first = 0;
        cnt_a = 0;
        for (int n = 1; n <= 40; n++) begin
            step(2'b01, 4'h3);
            if (strobe[0] && first == 0) first = n;
            if (strobe_rise[0]) cnt_a++;
        end
        chk("t1_latency", 32'(first), 32'(S + D + 1));
        chk("t1_rise_cnt", 32'(cnt_a), 32'd1);
        chk("t1_glitch", 32'(glitch_count), 32'd0);
        // 2: data settles, channel 1 rises
        repeat (5) step(2'b01, 4'hA);
        cnt_a = 0;
        for (int n = 0; n < 30; n++) begin
            step(2'b11, 4'hA);
            if (capture_valid) cnt_a++;
        end
        chk("t2_cv_cnt", 32'(cnt_a), 32'd1);
        chk("t2_data", 32'(data_captured), 32'hA);
        chk("t2_chan", 32'(capture_chan), 32'h2);
        repeat (30) step(2'b00, 4'hA);
        // 3: short pulse is rejected
        cnt_a = 0;
        repeat (5) step(2'b01, 4'h7);
        for (int n = 0; n < 25; n++) begin
            step(2'b00, 4'h7);
            if (strobe != 0 || strobe_rise != 0 ||
                strobe_fall != 0) cnt_a++;
        end
        chk("t3_activity", 32'(cnt_a), 32'd0);
        chk("t3_glitch", 32'(glitch_count), 32'd1);
        // 4: simultaneous rise
        repeat (4) step(2'b00, 4'h5);
        cnt_a = 0;
        cnt_b = 0;
        for (int n = 0; n < 30; n++) begin
            step(2'b11, 4'h5);
            if (capture_valid) cnt_a++;
            if (strobe_rise == 2'b11) cnt_b++;
        end
        chk("t4_cv_cnt", 32'(cnt_a), 32'd1);
        chk("t4_rise11", 32'(cnt_b), 32'd1);
        chk("t4_data", 32'(data_captured), 32'h5);
        chk("t4_chan", 32'(capture_chan), 32'h3);
        repeat (30) step(2'b00, 4'h5);
        // 5: bounce until saturation
        cnt_a = 0;
        for (int n = 0; n < 300; n++) begin
            step(2'b01, 4'h1);
            step(2'b01, 4'h1);
            step(2'b00, 4'h1);
            step(2'b00, 4'h1);
            if (strobe != 0) cnt_a++;
        end
        chk("t5_glitch", 32'(glitch_count), 32'd255);
        chk("t5_strobe", 32'(cnt_a), 32'd0);
        // random patterns
        hold[0] = 0;
        hold[1] = 0;
        rs = '0;
        for (int n = 0; n < 1500; n++) begin
            for (int c = 0; c < 2; c++) begin
                if (hold[c] == 0) begin
                    rs[c]   = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 24);
                end
                hold[c]--;
            end
            step(rs, 4'($urandom));
        end
        // 6: reset in the middle of PEND_LO
        repeat (25) step(2'b01, 4'h9);
        chk("t6_high", 32'(strobe), 32'h1);
        repeat (S + 1 + 7) step(2'b00, 4'h9);
        do_reset(2);
        cnt_a = 0;
        for (int n = 0; n < 30; n++) begin
            step(2'b00, 4'h9);
            if (strobe_fall != 0 || strobe != 0) cnt_a++;
        end
        chk("t6_after", 32'(cnt_a), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
